// File: rtl/tsn_cmd_pkg.sv
// tsn_cmd_pkg: shared command field positions, type/target codes, register map and FSM types
package tsn_cmd_pkg;
  localparam int CMD_W    = 204;
  localparam int TGT_MSB  = 195;
  localparam int TGT_LSB  = 188;
  localparam int TYPE_MSB = 187;
  localparam int TYPE_LSB = 184;
  localparam int ADDR_MSB = 183;
  localparam int ADDR_LSB = 152;
  localparam int DATA_W   = 152;
  localparam logic [3:0] CMD_WR   = 4'h1;
  localparam logic [3:0] CMD_RD   = 4'h2;
  localparam logic [3:0] CMD_ACK  = 4'h6;
  localparam logic [3:0] CMD_NACK = 4'h7;
  localparam logic [7:0] TGT_REG      = 8'h00;
  localparam logic [7:0] TGT_NOP_BASE = 8'h03;
  localparam logic [7:0] TGT_FLT      = 8'h0C;
  localparam logic [31:0] REG_CFG_FINISH = 32'h03;
  localparam logic [31:0] REG_PORT_TYPE  = 32'h04;
  localparam logic [31:0] REG_QBV_OR_QCH = 32'h05;
  localparam logic [31:0] REG_BE_THR     = 32'h0C;
  localparam logic [31:0] REG_RC_THR     = 32'h0D;
  localparam logic [31:0] REG_MAP_THR    = 32'h0E;
  localparam logic [31:0] REG_STATUS     = 32'h10;
  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT, RD_RESP} rd_state_e;
  typedef enum logic [1:0] {K_REG, K_NOP, K_FLT, K_BAD} tgt_kind_e;
  function automatic tgt_kind_e tgt_kind(input logic [7:0] tgt, input int port_num);
    return tgt == TGT_REG ? K_REG :
           tgt == TGT_FLT ? K_FLT :
           (tgt >= TGT_NOP_BASE && int'(tgt) < int'(TGT_NOP_BASE) + port_num) ? K_NOP : K_BAD;
  endfunction
endpackage

// File: rtl/cmd_rd_engine.sv
// cmd_rd_engine: read FSM honouring RAM latency, rdata mux and ack/nack word formatter
//   iv_cmd/i_cmd_wr      read command, taken only while o_ready
//   i_stall              a write owns the targeted RAM this cycle; hold in ISSUE
//   iv_reg_rdata         register value selected by ov_addr (sampled at end of ISSUE)
//   iv_nop_rdata/iv_flt_rdata  RAM read data
//   ov_issue_nop/o_issue_flt   RAM the engine wants this cycle (for collision detect)
//   ov_nop_rd/o_flt_rd   actual read strobes; ov_addr latched read address
//   ov_ack/o_ack_wr      ack or nack word with one-cycle valid; o_nack_inc on illegal read
module cmd_rd_engine
  import tsn_cmd_pkg::*;
#(
  parameter int PORT_NUM   = 5,
  parameter int NOP_DW     = 8,
  parameter int FLT_DW     = 9,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [CMD_W-1:0]           iv_cmd,
  input  logic                       i_cmd_wr,
  input  logic                       i_stall,
  input  logic [31:0]                iv_reg_rdata,
  input  logic [PORT_NUM*NOP_DW-1:0] iv_nop_rdata,
  input  logic [FLT_DW-1:0]          iv_flt_rdata,
  output logic                       o_ready,
  output logic                       o_nack_inc,
  output logic [31:0]                ov_addr,
  output logic [PORT_NUM-1:0]        ov_issue_nop,
  output logic                       o_issue_flt,
  output logic [PORT_NUM-1:0]        ov_nop_rd,
  output logic                       o_flt_rd,
  output logic [CMD_W-1:0]           ov_ack,
  output logic                       o_ack_wr
);
  rd_state_e state_q, state_d;
  tgt_kind_e kind_q, kind_d, cmd_kind;
  logic [7:0] tgt_q, tgt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0] port_q, port_d;
  logic [2:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0] cmd_tgt;
  logic cmd_bad;
  logic unused_cmd;
  assign cmd_tgt    = iv_cmd[TGT_MSB:TGT_LSB];
  assign cmd_kind   = tgt_kind(cmd_tgt, PORT_NUM);
  assign cmd_bad    = cmd_kind == K_BAD || iv_cmd[TYPE_MSB:TYPE_LSB] != CMD_RD;
  assign unused_cmd = ^{iv_cmd[CMD_W-1:TGT_MSB+1], iv_cmd[DATA_W-1:0]};
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      RD_IDLE: if (i_cmd_wr) begin
        state_d = RD_ISSUE;
        kind_d  = cmd_bad ? K_BAD : cmd_kind;
        tgt_d   = cmd_tgt;
        addr_d  = iv_cmd[ADDR_MSB:ADDR_LSB];
        port_d  = 4'(cmd_tgt - TGT_NOP_BASE);
        cnt_d   = '0;
        data_d  = '0;
      end
      RD_ISSUE: begin
        // register reads and nacks skip the RAM wait entirely
        data_d  = kind_q == K_REG ? DATA_W'(iv_reg_rdata) : data_q;
        state_d = (kind_q == K_REG || kind_q == K_BAD) ? RD_RESP : i_stall ? RD_ISSUE : RD_WAIT;
      end
      RD_WAIT: if (cnt_q == 3'(RAM_RD_LAT - 1)) begin
        data_d  = kind_q == K_FLT ? DATA_W'(iv_flt_rdata) : DATA_W'(iv_nop_rdata[port_q*NOP_DW +: NOP_DW]);
        state_d = RD_RESP;
      end else
        cnt_d = cnt_q + 3'd1;
      default: state_d = RD_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= RD_IDLE;
      kind_q  <= K_REG;
      tgt_q   <= '0;
      addr_q  <= '0;
      port_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  assign o_ready      = state_q == RD_IDLE;
  assign o_nack_inc   = state_q == RD_IDLE && i_cmd_wr && cmd_bad;
  assign ov_addr      = addr_q;
  assign ov_issue_nop = (state_q == RD_ISSUE && kind_q == K_NOP) ? PORT_NUM'(1) << port_q : '0;
  assign o_issue_flt  = state_q == RD_ISSUE && kind_q == K_FLT;
  assign ov_nop_rd    = i_stall ? '0 : ov_issue_nop;
  assign o_flt_rd     = o_issue_flt && !i_stall;
  assign o_ack_wr     = state_q == RD_RESP;
  assign ov_ack       = o_ack_wr ? {8'h00, tgt_q, kind_q == K_BAD ? CMD_NACK : CMD_ACK, addr_q, data_q} : '0;
endmodule

// File: rtl/cmd_parser_param.sv
// cmd_parser_param: decodes configuration commands into register updates and NOP/FLT RAM accesses
//   iv_wr_command/i_wr_command_wr   write command, always accepted; effect one cycle later
//   iv_rd_command/i_rd_command_wr   read command, accepted while o_rd_command_ready
//   ov_rd_command_ack/_wr           ack (type 6) or nack (type 7) word with one-cycle valid
//   ov_*_threshold_value, ov_port_type, ov_cfg_finish, o_qbv_or_qch   configuration registers
//   ov_nop_ram_* / *flt_ram_*       RAM ports; address/wdata are zero unless a strobe is active
module cmd_parser_param
  import tsn_cmd_pkg::*;
#(
  parameter int PORT_NUM   = 5,
  parameter int NOP_AW     = 10,
  parameter int NOP_DW     = 8,
  parameter int FLT_AW     = 14,
  parameter int FLT_DW     = 9,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [CMD_W-1:0]           iv_wr_command,
  input  logic                       i_wr_command_wr,
  input  logic [CMD_W-1:0]           iv_rd_command,
  input  logic                       i_rd_command_wr,
  output logic                       o_rd_command_ready,
  output logic [CMD_W-1:0]           ov_rd_command_ack,
  output logic                       o_rd_command_ack_wr,
  output logic [8:0]                 ov_be_threshold_value,
  output logic [8:0]                 ov_rc_threshold_value,
  output logic [8:0]                 ov_map_req_threshold_value,
  output logic [PORT_NUM-1:0]        ov_port_type,
  output logic [1:0]                 ov_cfg_finish,
  output logic                       o_qbv_or_qch,
  output logic [PORT_NUM*NOP_AW-1:0] ov_nop_ram_addr,
  output logic [PORT_NUM*NOP_DW-1:0] ov_nop_ram_wdata,
  output logic [PORT_NUM-1:0]        ov_nop_ram_wr,
  output logic [PORT_NUM-1:0]        ov_nop_ram_rd,
  input  logic [PORT_NUM*NOP_DW-1:0] iv_nop_ram_rdata,
  output logic [FLT_AW-1:0]          ov_flt_ram_addr,
  output logic [FLT_DW-1:0]          ov_flt_ram_wdata,
  output logic                       o_flt_ram_wr,
  output logic                       o_flt_ram_rd,
  input  logic [FLT_DW-1:0]          iv_flt_ram_rdata
);
  localparam int WA = NOP_AW > FLT_AW ? NOP_AW : FLT_AW;
  localparam int WD = NOP_DW > FLT_DW ? NOP_DW : FLT_DW;
  logic [7:0] wr_tgt;
  logic [31:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  tgt_kind_e wr_kind;
  logic wr_legal, wr_ok, reg_we;
  logic [1:0] cfg_finish_q, cfg_finish_d;
  logic [PORT_NUM-1:0] port_type_q, port_type_d;
  logic qbv_q, qbv_d;
  logic [8:0] be_thr_q, be_thr_d, rc_thr_q, rc_thr_d, map_thr_q, map_thr_d;
  logic [15:0] wr_cnt_q, wr_cnt_d, nack_cnt_q, nack_cnt_d;
  logic [PORT_NUM-1:0] nop_wr_q, nop_wr_d;
  logic flt_wr_q, flt_wr_d;
  logic [WA-1:0] wr_addr_q, wr_addr_d;
  logic [WD-1:0] wr_data_q, wr_data_d;
  logic rd_nack, stall, issue_flt, flt_rd;
  logic [31:0] rd_addr, reg_rdata;
  logic [PORT_NUM-1:0] issue_nop, nop_rd;
  logic unused_bits;
  assign wr_tgt      = iv_wr_command[TGT_MSB:TGT_LSB];
  assign wr_addr     = iv_wr_command[ADDR_MSB:ADDR_LSB];
  assign wr_data     = iv_wr_command[DATA_W-1:0];
  assign wr_kind     = tgt_kind(wr_tgt, PORT_NUM);
  assign unused_bits = ^{iv_wr_command, rd_addr};
  always_comb begin
    wr_legal     = iv_wr_command[TYPE_MSB:TYPE_LSB] == CMD_WR && wr_kind != K_BAD &&
                   !(wr_kind == K_REG && wr_addr == REG_STATUS);
    wr_ok        = i_wr_command_wr && wr_legal;
    reg_we       = wr_ok && wr_kind == K_REG;
    cfg_finish_d = reg_we && wr_addr == REG_CFG_FINISH ? wr_data[1:0] : cfg_finish_q;
    port_type_d  = reg_we && wr_addr == REG_PORT_TYPE ? wr_data[PORT_NUM-1:0] : port_type_q;
    qbv_d        = reg_we && wr_addr == REG_QBV_OR_QCH ? wr_data[0] : qbv_q;
    be_thr_d     = reg_we && wr_addr == REG_BE_THR ? wr_data[8:0] : be_thr_q;
    rc_thr_d     = reg_we && wr_addr == REG_RC_THR ? wr_data[8:0] : rc_thr_q;
    map_thr_d    = reg_we && wr_addr == REG_MAP_THR ? wr_data[8:0] : map_thr_q;
    nop_wr_d     = wr_ok && wr_kind == K_NOP ? PORT_NUM'(1) << 4'(wr_tgt - TGT_NOP_BASE) : '0;
    flt_wr_d     = wr_ok && wr_kind == K_FLT;
    wr_addr_d    = (|nop_wr_d || flt_wr_d) ? wr_addr[WA-1:0] : '0;
    wr_data_d    = (|nop_wr_d || flt_wr_d) ? wr_data[WD-1:0] : '0;
    wr_cnt_d     = wr_cnt_q + 16'(wr_ok);
    // an illegal write and an illegal read may land in the same cycle
    nack_cnt_d   = nack_cnt_q + 16'(i_wr_command_wr && !wr_legal) + 16'(rd_nack);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cfg_finish_q <= '0;
      port_type_q  <= '1;
      qbv_q        <= 1'b0;
      be_thr_q     <= '0;
      rc_thr_q     <= '0;
      map_thr_q    <= '0;
      wr_cnt_q     <= '0;
      nack_cnt_q   <= '0;
      nop_wr_q     <= '0;
      flt_wr_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      cfg_finish_q <= cfg_finish_d;
      port_type_q  <= port_type_d;
      qbv_q        <= qbv_d;
      be_thr_q     <= be_thr_d;
      rc_thr_q     <= rc_thr_d;
      map_thr_q    <= map_thr_d;
      wr_cnt_q     <= wr_cnt_d;
      nack_cnt_q   <= nack_cnt_d;
      nop_wr_q     <= nop_wr_d;
      flt_wr_q     <= flt_wr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  // the write strobe owns the shared RAM port; a read aimed at the same RAM waits a cycle
  assign stall = |(issue_nop & nop_wr_q) || (issue_flt && flt_wr_q);
  assign reg_rdata = rd_addr == REG_CFG_FINISH ? 32'(cfg_finish_q) :
                     rd_addr == REG_PORT_TYPE  ? 32'(port_type_q) :
                     rd_addr == REG_QBV_OR_QCH ? 32'(qbv_q) :
                     rd_addr == REG_BE_THR     ? 32'(be_thr_q) :
                     rd_addr == REG_RC_THR     ? 32'(rc_thr_q) :
                     rd_addr == REG_MAP_THR    ? 32'(map_thr_q) :
                     rd_addr == REG_STATUS     ? {nack_cnt_q, wr_cnt_q} : '0;
  cmd_rd_engine #(
    .PORT_NUM(PORT_NUM), .NOP_DW(NOP_DW), .FLT_DW(FLT_DW), .RAM_RD_LAT(RAM_RD_LAT)
  ) u_rd (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .iv_cmd       (iv_rd_command),
    .i_cmd_wr     (i_rd_command_wr),
    .i_stall      (stall),
    .iv_reg_rdata (reg_rdata),
    .iv_nop_rdata (iv_nop_ram_rdata),
    .iv_flt_rdata (iv_flt_ram_rdata),
    .o_ready      (o_rd_command_ready),
    .o_nack_inc   (rd_nack),
    .ov_addr      (rd_addr),
    .ov_issue_nop (issue_nop),
    .o_issue_flt  (issue_flt),
    .ov_nop_rd    (nop_rd),
    .o_flt_rd     (flt_rd),
    .ov_ack       (ov_rd_command_ack),
    .o_ack_wr     (o_rd_command_ack_wr)
  );
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_port
    assign ov_nop_ram_addr[g*NOP_AW +: NOP_AW]  = nop_wr_q[g] ? wr_addr_q[NOP_AW-1:0] :
                                                  nop_rd[g] ? rd_addr[NOP_AW-1:0] : '0;
    assign ov_nop_ram_wdata[g*NOP_DW +: NOP_DW] = nop_wr_q[g] ? wr_data_q[NOP_DW-1:0] : '0;
  end
  assign ov_nop_ram_wr              = nop_wr_q;
  assign ov_nop_ram_rd              = nop_rd;
  assign o_flt_ram_wr               = flt_wr_q;
  assign o_flt_ram_rd               = flt_rd;
  assign ov_flt_ram_addr            = flt_wr_q ? wr_addr_q[FLT_AW-1:0] : flt_rd ? rd_addr[FLT_AW-1:0] : '0;
  assign ov_flt_ram_wdata           = flt_wr_q ? wr_data_q[FLT_DW-1:0] : '0;
  assign ov_cfg_finish              = cfg_finish_q;
  assign ov_port_type               = port_type_q;
  assign o_qbv_or_qch               = qbv_q;
  assign ov_be_threshold_value      = be_thr_q;
  assign ov_rc_threshold_value      = rc_thr_q;
  assign ov_map_req_threshold_value = map_thr_q;
endmodule
